sobel_window_gen: RTL and testbench
===================================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: active pixels per line; line buffer depth.
REQ-002 SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port pixel_in, input, DATA_W bits: raster-order grayscale pixel, valid when de=1.
REQ-006 SHALL have ports hsync, vsync and de, inputs, 1 bit each: video timing for pixel_in.
REQ-007 SHALL have ports pixel_out1..pixel_out9, outputs, DATA_W bits each: 3x3 window, row-major; 1 = top-left, 9 = bottom-right.
REQ-008 SHALL have ports hsync_out, vsync_out and de_out, outputs, 1 bit each: timing aligned with the window.
REQ-009 SHALL have port window_valid, output, 1 bit: window fully inside the image.

Function
REQ-010 SHALL register every output, giving one-cycle latency: outputs in cycle t+1 reflect inputs in cycle t.
REQ-011 SHALL drive hsync_out, vsync_out and de_out as hsync, vsync and de delayed by exactly one cycle.
REQ-012 SHALL keep a column counter col of ceil(log2(IMG_WIDTH+1)) bits that increments on each de=1 cycle and saturates at IMG_WIDTH.
REQ-013 SHALL clear col to 0 on each falling edge of de (de=0 in the current cycle, de=1 in the previous cycle).
REQ-014 SHALL keep a line counter line, 2 bits, that saturates at 2 and increments on each de falling edge.
REQ-015 SHALL clear line to 0 on each vsync rising edge; if a vsync rising edge and a de falling edge occur in the same cycle, the clear wins.
REQ-016 SHALL contain two line buffers, LB0 (previous line) and LB1 (line before previous), each IMG_WIDTH x DATA_W.
REQ-017 SHALL, on a de=1 cycle with col<IMG_WIDTH, read LB0[col] and LB1[col] (read-before-write), write pixel_in into LB0[col], and write the old LB0[col] into LB1[col].
REQ-018 SHALL leave both line buffers unchanged and drive window_valid=0 on a de=1 cycle with col=IMG_WIDTH (overlong line).
REQ-019 SHALL maintain three 3-deep column shift registers (top row = LB1 read, middle row = LB0 read, bottom row = pixel_in) that shift only on de=1 cycles.
REQ-020 SHALL map the newest sample of each row to pixel_out3, pixel_out6 and pixel_out9, and the oldest to pixel_out1, pixel_out4 and pixel_out7.
REQ-021 SHALL, for the window produced from a de=1 cycle at column c, zero pixel_out1,2,4,5,7,8 when c=0, and zero pixel_out1,4,7 when c=1.
REQ-022 SHALL, for that window, zero pixel_out1..6 when line=0, and zero pixel_out1..3 when line=1.
REQ-023 SHALL drive window_valid=1 in cycle t+1 iff de=1, col>=2, col<IMG_WIDTH and line=2 in cycle t.
REQ-024 SHALL hold pixel_out1..9 at their last values while de=0, and drive window_valid=0 in those cycles.
REQ-025 SHALL not interpret hsync internally; hsync is passthrough only.

Reset
REQ-026 SHALL, while rst=0 at a clock edge, clear all pixel outputs, hsync_out, vsync_out, de_out, window_valid, col, line, the shift registers and the edge-detect history to 0.
REQ-027 SHALL not clear line buffer contents on reset; the masking in REQ-021 and REQ-022 hides stale data.
REQ-028 SHALL treat the first line after reset is released as line 0, even when reset occurs mid-frame.

Verification (IMG_WIDTH=4, DATA_W=8)
REQ-029 SHALL cover this scenario: 3 lines of 4 pixels, value = 16*line+col+1, 2 blanking cycles between lines; at line 2, col 2 -> next cycle pixel_out1..9 = 1,2,3,17,18,19,33,34,35 and window_valid=1.
REQ-030 SHALL cover this scenario: line 0, col 0, pixel 9 -> pixel_out9=9, all other pixel outputs 0, window_valid=0.
REQ-031 SHALL cover this scenario: line 2 with 6 pixels -> window_valid=0 for pixels 5 and 6; the following line's top and middle rows still show the original 4-pixel lines.
REQ-032 SHALL cover this scenario: vsync rising edge after 3 lines -> next line is treated as line 0, with pixel_out1..6=0 for all of its windows.
REQ-033 SHALL cover this scenario: rst=0 during line 1, col 2 -> all outputs 0 the next cycle; after release, the next line masks as line 0.
REQ-034 SHALL cover this scenario: hsync=1 for one cycle with de=0 -> hsync_out=1 exactly one cycle later, pixel outputs unchanged.

Source files
------------

// File: rtl/sobel_window_gen_if.sv
// Video-in / 3x3-window-out bundle for sobel_window_gen.
interface sobel_window_gen_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] pixel_in;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [DATA_W-1:0] pixel_out1;
  logic [DATA_W-1:0] pixel_out2;
  logic [DATA_W-1:0] pixel_out3;
  logic [DATA_W-1:0] pixel_out4;
  logic [DATA_W-1:0] pixel_out5;
  logic [DATA_W-1:0] pixel_out6;
  logic [DATA_W-1:0] pixel_out7;
  logic [DATA_W-1:0] pixel_out8;
  logic [DATA_W-1:0] pixel_out9;
  logic              hsync_out;
  logic              vsync_out;
  logic              de_out;
  logic              window_valid;

  // Video source side.
  modport master (
    output pixel_in, hsync, vsync, de,
    input  pixel_out1, pixel_out2, pixel_out3, pixel_out4, pixel_out5,
    input  pixel_out6, pixel_out7, pixel_out8, pixel_out9,
    input  hsync_out, vsync_out, de_out, window_valid
  );

  // Window generator side.
  modport slave (
    input  pixel_in, hsync, vsync, de,
    output pixel_out1, pixel_out2, pixel_out3, pixel_out4, pixel_out5,
    output pixel_out6, pixel_out7, pixel_out8, pixel_out9,
    output hsync_out, vsync_out, de_out, window_valid
  );
endinterface

// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for raster video: two line buffers plus three
// 3-deep column shift registers, with border masking and a one-cycle latency.
module sobel_window_gen #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned DATA_W    = 8
) (
  input logic            clk,
  input logic            rst,
  sobel_window_gen_if.slave bus
);
  localparam int unsigned ColW  = $clog2(IMG_WIDTH + 1);
  localparam int unsigned AddrW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_WIDTH);

  typedef logic [DATA_W-1:0] pix_t;

  logic [ColW-1:0] col_q, col_d;
  logic [1:0]      line_q, line_d;
  // Delayed timing doubles as the edge-detect history.
  logic            hsync_q, vsync_q, de_q;
  logic            valid_q, valid_d;
  pix_t            top_q [3], top_d [3];
  pix_t            mid_q [3], mid_d [3];
  pix_t            bot_q [3], bot_d [3];
  pix_t            win_q [9], win_d [9];
  pix_t            lb0_q [IMG_WIDTH];
  pix_t            lb1_q [IMG_WIDTH];

  logic             in_range, de_fall, vsync_rise, lb_wr;
  logic [AddrW-1:0] addr;
  pix_t             lb0_rd, lb1_rd;

  assign in_range   = (col_q < ColMax);
  assign de_fall    = !bus.de && de_q;
  assign vsync_rise = bus.vsync && !vsync_q;
  assign addr       = col_q[AddrW-1:0];
  assign lb_wr      = rst && bus.de && in_range;
  // Overlong-line columns have no buffer slot; feed zeros instead.
  assign lb0_rd     = in_range ? lb0_q[addr] : '0;
  assign lb1_rd     = in_range ? lb1_q[addr] : '0;

  // Column / line counters and their edge-driven clears.
  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (de_fall) begin
      col_d = '0;
    end else if (bus.de && in_range) begin
      col_d = col_q + ColW'(1);
    end
    // A vsync rising edge overrides a simultaneous de falling edge.
    if (vsync_rise) begin
      line_d = '0;
    end else if (de_fall && line_q != 2'd2) begin
      line_d = line_q + 2'd1;
    end
  end

  // Shift the column registers and build the masked window on de cycles.
  always_comb begin
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    win_d   = win_q;
    valid_d = 1'b0;
    if (bus.de) begin
      top_d[0] = top_q[1];
      top_d[1] = top_q[2];
      top_d[2] = lb1_rd;
      mid_d[0] = mid_q[1];
      mid_d[1] = mid_q[2];
      mid_d[2] = lb0_rd;
      bot_d[0] = bot_q[1];
      bot_d[1] = bot_q[2];
      bot_d[2] = bus.pixel_in;
      for (int c = 0; c < 3; c++) begin
        win_d[c]     = top_d[c];
        win_d[3 + c] = mid_d[c];
        win_d[6 + c] = bot_d[c];
      end
      // Left border: columns not yet seen hold stale data.
      if (col_q == '0) begin
        for (int r = 0; r < 3; r++) begin
          win_d[3 * r]     = '0;
          win_d[3 * r + 1] = '0;
        end
      end else if (col_q == ColW'(1)) begin
        for (int r = 0; r < 3; r++) begin
          win_d[3 * r] = '0;
        end
      end
      // Top border: line buffers do not yet hold rows of this frame.
      if (line_q == 2'd0) begin
        for (int i = 0; i < 6; i++) begin
          win_d[i] = '0;
        end
      end else if (line_q == 2'd1) begin
        for (int i = 0; i < 3; i++) begin
          win_d[i] = '0;
        end
      end
      valid_d = (col_q >= ColW'(2)) && in_range && (line_q == 2'd2);
    end
  end

  // Control and window state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q   <= '0;
      line_q  <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      line_q  <= line_d;
      hsync_q <= bus.hsync;
      vsync_q <= bus.vsync;
      de_q    <= bus.de;
      valid_q <= valid_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      win_q   <= win_d;
    end
  end

  // Line buffers: not reset, old LB0 entry cascades into LB1.
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      lb0_q[addr] <= bus.pixel_in;
      lb1_q[addr] <= lb0_rd;
    end
  end

  assign bus.pixel_out1   = win_q[0];
  assign bus.pixel_out2   = win_q[1];
  assign bus.pixel_out3   = win_q[2];
  assign bus.pixel_out4   = win_q[3];
  assign bus.pixel_out5   = win_q[4];
  assign bus.pixel_out6   = win_q[5];
  assign bus.pixel_out7   = win_q[6];
  assign bus.pixel_out8   = win_q[7];
  assign bus.pixel_out9   = win_q[8];
  assign bus.hsync_out    = hsync_q;
  assign bus.vsync_out    = vsync_q;
  assign bus.de_out       = de_q;
  assign bus.window_valid = valid_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen at IMG_WIDTH=4, DATA_W=8.
module tb_sobel_window_gen;
  localparam int unsigned W = 4;
  // Flag vectors: {hsync_out, vsync_out, de_out, window_valid}
  localparam logic [3:0] F0  = 4'b0000;
  localparam logic [3:0] FDE = 4'b0010;
  localparam logic [3:0] FV  = 4'b0011;
  localparam logic [3:0] FVS = 4'b0100;
  localparam logic [3:0] FHS = 4'b1000;

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    int          pix;
    logic        cp;
    logic [71:0] ep;
    logic [3:0]  ef;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sobel_window_gen_if #(.DATA_W(8)) bus ();

  sobel_window_gen #(
    .IMG_WIDTH(W),
    .DATA_W   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [71:0] p9(input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6,
                                     input int a7, input int a8, input int a9);
    return {a1[7:0], a2[7:0], a3[7:0], a4[7:0], a5[7:0], a6[7:0], a7[7:0], a8[7:0], a9[7:0]};
  endfunction

  function automatic vec_t mk(input logic de, input logic hs, input logic vs, input int pix,
                              input logic cp, input logic [71:0] ep, input logic [3:0] ef);
    vec_t v;
    v.de = de; v.hs = hs; v.vs = vs; v.pix = pix; v.cp = cp; v.ep = ep; v.ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the rising edge.
  task automatic run(input string name, input logic r, input logic de, input logic hs,
                     input logic vs, input int pix, input logic cp, input logic [71:0] ep,
                     input logic [3:0] ef);
    logic [71:0] outs;
    logic [3:0]  flags;
    @(negedge clk);
    rst          = r;
    bus.de       = de;
    bus.hsync    = hs;
    bus.vsync    = vs;
    bus.pixel_in = pix[7:0];
    @(posedge clk);
    #1;
    outs  = {bus.pixel_out1, bus.pixel_out2, bus.pixel_out3, bus.pixel_out4, bus.pixel_out5,
             bus.pixel_out6, bus.pixel_out7, bus.pixel_out8, bus.pixel_out9};
    flags = {bus.hsync_out, bus.vsync_out, bus.de_out, bus.window_valid};
    if (cp) check({name, " pixels"}, outs, ep);
    check({name, " flags"}, {68'd0, flags}, {68'd0, ef});
  endtask

  initial begin
    vec_t tbl[$];
    rst          = 1'b0;
    bus.de       = 1'b0;
    bus.hsync    = 1'b0;
    bus.vsync    = 1'b0;
    bus.pixel_in = '0;

    run("reset0", 0, 0, 0, 0, 0, 1, '0, F0);
    run("reset1", 0, 0, 0, 0, 0, 1, '0, F0);

    // Three 4-pixel lines, value 16*line+col+1, two blanking cycles between.
    tbl.push_back(mk(1, 0, 0, 1,  1, p9(0, 0, 0, 0, 0, 0, 0, 0, 1), FDE));
    tbl.push_back(mk(1, 0, 0, 2,  1, p9(0, 0, 0, 0, 0, 0, 0, 1, 2), FDE));
    tbl.push_back(mk(1, 0, 0, 3,  1, p9(0, 0, 0, 0, 0, 0, 1, 2, 3), FDE));
    tbl.push_back(mk(1, 0, 0, 4,  1, p9(0, 0, 0, 0, 0, 0, 2, 3, 4), FDE));
    tbl.push_back(mk(0, 0, 0, 0,  1, p9(0, 0, 0, 0, 0, 0, 2, 3, 4), F0));
    tbl.push_back(mk(0, 0, 0, 0,  1, p9(0, 0, 0, 0, 0, 0, 2, 3, 4), F0));
    tbl.push_back(mk(1, 0, 0, 17, 1, p9(0, 0, 0, 0, 0, 1, 0, 0, 17), FDE));
    tbl.push_back(mk(1, 0, 0, 18, 1, p9(0, 0, 0, 0, 1, 2, 0, 17, 18), FDE));
    tbl.push_back(mk(1, 0, 0, 19, 1, p9(0, 0, 0, 1, 2, 3, 17, 18, 19), FDE));
    tbl.push_back(mk(1, 0, 0, 20, 1, p9(0, 0, 0, 2, 3, 4, 18, 19, 20), FDE));
    tbl.push_back(mk(0, 0, 0, 0,  1, p9(0, 0, 0, 2, 3, 4, 18, 19, 20), F0));
    tbl.push_back(mk(0, 0, 0, 0,  1, p9(0, 0, 0, 2, 3, 4, 18, 19, 20), F0));
    tbl.push_back(mk(1, 0, 0, 33, 1, p9(0, 0, 1, 0, 0, 17, 0, 0, 33), FDE));
    tbl.push_back(mk(1, 0, 0, 34, 1, p9(0, 1, 2, 0, 17, 18, 0, 33, 34), FDE));
    tbl.push_back(mk(1, 0, 0, 35, 1, p9(1, 2, 3, 17, 18, 19, 33, 34, 35), FV));
    tbl.push_back(mk(1, 0, 0, 36, 1, p9(2, 3, 4, 18, 19, 20, 34, 35, 36), FV));
    tbl.push_back(mk(0, 0, 0, 0,  1, p9(2, 3, 4, 18, 19, 20, 34, 35, 36), F0));
    tbl.push_back(mk(0, 0, 0, 0,  1, p9(2, 3, 4, 18, 19, 20, 34, 35, 36), F0));
    foreach (tbl[i]) begin
      run($sformatf("vec%0d", i), 1, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].pix,
          tbl[i].cp, tbl[i].ep, tbl[i].ef);
    end

    // Overlong 6-pixel line: last two columns invalid, buffers keep first 4.
    run("long_c0", 1, 1, 0, 0, 49, 1, p9(0, 0, 17, 0, 0, 33, 0, 0, 49), FDE);
    run("long_c1", 1, 1, 0, 0, 50, 1, p9(0, 17, 18, 0, 33, 34, 0, 49, 50), FDE);
    run("long_c2", 1, 1, 0, 0, 51, 1, p9(17, 18, 19, 33, 34, 35, 49, 50, 51), FV);
    run("long_c3", 1, 1, 0, 0, 52, 1, p9(18, 19, 20, 34, 35, 36, 50, 51, 52), FV);
    run("long_c4", 1, 1, 0, 0, 53, 0, '0, FDE);
    run("long_c5", 1, 1, 0, 0, 54, 0, '0, FDE);
    run("long_b0", 1, 0, 0, 0, 0, 0, '0, F0);
    run("long_b1", 1, 0, 0, 0, 0, 0, '0, F0);
    run("after_c0", 1, 1, 0, 0, 65, 1, p9(0, 0, 33, 0, 0, 49, 0, 0, 65), FDE);
    run("after_c1", 1, 1, 0, 0, 66, 1, p9(0, 33, 34, 0, 49, 50, 0, 65, 66), FDE);
    run("after_c2", 1, 1, 0, 0, 67, 1, p9(33, 34, 35, 49, 50, 51, 65, 66, 67), FV);
    run("after_c3", 1, 1, 0, 0, 68, 1, p9(34, 35, 36, 50, 51, 52, 66, 67, 68), FV);

    // vsync rise coincident with de fall: clear wins, next line is line 0.
    run("vs_rise", 1, 0, 0, 1, 0, 1, p9(34, 35, 36, 50, 51, 52, 66, 67, 68), FVS);
    run("vs_low", 1, 0, 0, 0, 0, 1, p9(34, 35, 36, 50, 51, 52, 66, 67, 68), F0);
    run("f2_c0", 1, 1, 0, 0, 9, 1, p9(0, 0, 0, 0, 0, 0, 0, 0, 9), FDE);
    run("f2_c1", 1, 1, 0, 0, 10, 1, p9(0, 0, 0, 0, 0, 0, 0, 9, 10), FDE);
    run("f2_c2", 1, 1, 0, 0, 11, 1, p9(0, 0, 0, 0, 0, 0, 9, 10, 11), FDE);
    run("f2_c3", 1, 1, 0, 0, 12, 1, p9(0, 0, 0, 0, 0, 0, 10, 11, 12), FDE);
    run("f2_b0", 1, 0, 0, 0, 0, 1, p9(0, 0, 0, 0, 0, 0, 10, 11, 12), F0);
    run("f2_b1", 1, 0, 0, 0, 0, 1, p9(0, 0, 0, 0, 0, 0, 10, 11, 12), F0);

    // Reset during line 1, col 2; line after release masks as line 0.
    run("l1_c0", 1, 1, 0, 0, 20, 1, p9(0, 0, 0, 0, 0, 9, 0, 0, 20), FDE);
    run("l1_c1", 1, 1, 0, 0, 21, 1, p9(0, 0, 0, 0, 9, 10, 0, 20, 21), FDE);
    run("mid_rst", 0, 1, 0, 0, 22, 1, '0, F0);
    run("rel_b0", 1, 0, 0, 0, 0, 1, '0, F0);
    run("rel_b1", 1, 0, 0, 0, 0, 1, '0, F0);
    run("rel_c0", 1, 1, 0, 0, 5, 1, p9(0, 0, 0, 0, 0, 0, 0, 0, 5), FDE);
    run("rel_c1", 1, 1, 0, 0, 6, 1, p9(0, 0, 0, 0, 0, 0, 0, 5, 6), FDE);
    run("rel_c2", 1, 1, 0, 0, 7, 1, p9(0, 0, 0, 0, 0, 0, 5, 6, 7), FDE);
    run("rel_c3", 1, 1, 0, 0, 8, 1, p9(0, 0, 0, 0, 0, 0, 6, 7, 8), FDE);

    // hsync pulse during blanking: passthrough only, window holds.
    run("hs_b0", 1, 0, 0, 0, 0, 1, p9(0, 0, 0, 0, 0, 0, 6, 7, 8), F0);
    run("hs_hi", 1, 0, 1, 0, 0, 1, p9(0, 0, 0, 0, 0, 0, 6, 7, 8), FHS);
    run("hs_lo", 1, 0, 0, 0, 0, 1, p9(0, 0, 0, 0, 0, 0, 6, 7, 8), F0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
